// File: rtl/sda_sel_multi.sv
// Multi-channel registered SDA drive select with per-channel data-hold timer.
// Define SDA_SEL_ARB_EN to add sticky arbitration-loss detection and forced release.
module sda_sel_multi #(
  parameter int NUM_CH = 2,
  parameter int HOLD_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*NUM_CH-1:0]   sda_mode,
  input  logic [NUM_CH-1:0]     tx_out,
  input  logic [NUM_CH-1:0]     scl_fall,
  input  logic [HOLD_W-1:0]     hold_cycles,
  input  logic [NUM_CH-1:0]     sda_in,
  input  logic [NUM_CH-1:0]     arb_clr,
  output logic [NUM_CH-1:0]     sda_out,
  output logic [NUM_CH-1:0]     busy,
  output logic [NUM_CH-1:0]     arb_lost
);

  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } state_t;

  logic w_hold_zero;
  assign w_hold_zero = (hold_cycles == '0);

`ifndef SDA_SEL_ARB_EN
  logic w_unused;
  assign w_unused = ^{sda_in, arb_clr};
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t            r_state;
    logic [HOLD_W-1:0] r_cnt;
    logic              r_sda;
    logic [1:0]        w_mode;
    logic              w_tgt;
    logic              w_force;

    assign w_mode = sda_mode[2*g +: 2];

    always_comb begin
      w_tgt = 1'b1;
      unique case (w_mode)
        2'b00: w_tgt = 1'b1;
        2'b01: w_tgt = 1'b0;
        2'b10: w_tgt = 1'b1;
        2'b11: w_tgt = tx_out[g];
      endcase
    end

`ifdef SDA_SEL_ARB_EN
    logic r_arb;
    logic w_arb_set;

    assign w_arb_set = (w_mode == 2'b11) && (r_state == TRACK)
                       && r_sda && !sda_in[g];
    // A fresh loss releases the line on the same edge it is detected.
    assign w_force = r_arb | w_arb_set;

    always_ff @(posedge clk) begin
      if (rst)
        r_arb <= 1'b0;
      else if (w_arb_set)
        r_arb <= 1'b1;
      else if (arb_clr[g])
        r_arb <= 1'b0;
    end

    assign arb_lost[g] = r_arb;
`else
    assign w_force     = 1'b0;
    assign arb_lost[g] = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= TRACK;
        r_cnt   <= '0;
        r_sda   <= 1'b1;
      end else begin
        unique case (r_state)
          TRACK: begin
            if (scl_fall[g] && !w_hold_zero) begin
              r_cnt   <= hold_cycles;
              r_state <= HOLD;
            end else begin
              r_sda <= w_force | w_tgt;
            end
          end
          HOLD: begin
            // A new falling edge restarts the window from the current length.
            if (scl_fall[g]) begin
              r_cnt <= hold_cycles;
              if (w_hold_zero)
                r_state <= TRACK;
            end else if (r_cnt == HOLD_W'(1)) begin
              r_cnt   <= '0;
              r_state <= TRACK;
            end else begin
              r_cnt <= r_cnt - HOLD_W'(1);
            end
          end
        endcase
      end
    end

    assign sda_out[g] = r_sda;
    assign busy[g]    = (r_state == HOLD);
  end

endmodule

// File: tb/tb_sda_sel_multi.sv
// Self-checking bench for sda_sel_multi: directed scenarios plus random traffic
// compared against a timestamp-based reference model.
module tb_sda_sel_multi;

  localparam int NUM_CH = 2;
  localparam int HOLD_W = 4;
`ifdef SDA_SEL_ARB_EN
  localparam bit ARB = 1'b1;
`else
  localparam bit ARB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        sda_mode;
  logic [1:0]        tx_out;
  logic [1:0]        scl_fall;
  logic [3:0]        hold_cycles;
  logic [1:0]        sda_in;
  logic [1:0]        arb_clr;
  logic [1:0]        sda_out;
  logic [1:0]        busy;
  logic [1:0]        arb_lost;

  int errors = 0;
  int checks = 0;

  // Reference model: a channel is busy after edge n while n < hu[c].
  int         n = 0;
  int         hu [2];
  logic [1:0] m_sda  = 2'b11;
  logic [1:0] m_busy = 2'b00;
  logic [1:0] m_arb  = 2'b00;

  sda_sel_multi #(.NUM_CH(NUM_CH), .HOLD_W(HOLD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sda_mode   (sda_mode),
    .tx_out     (tx_out),
    .scl_fall   (scl_fall),
    .hold_cycles(hold_cycles),
    .sda_in     (sda_in),
    .arb_clr    (arb_clr),
    .sda_out    (sda_out),
    .busy       (busy),
    .arb_lost   (arb_lost)
  );

  always #5 clk = ~clk;

  task automatic tick();
    logic       bz, tg, set, frc;
    logic [1:0] md;
    n++;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        m_sda[c] = 1'b1;
        m_arb[c] = 1'b0;
        hu[c]    = 0;
      end else begin
        bz  = ((n - 1) < hu[c]);
        md  = sda_mode[2*c +: 2];
        tg  = (md == 2'd1) ? 1'b0 : (md == 2'd3) ? tx_out[c] : 1'b1;
        set = ARB && (md == 2'd3) && !bz && m_sda[c] && !sda_in[c];
        frc = m_arb[c] | set;
        if (!bz) begin
          if (scl_fall[c] && hold_cycles != 0)
            hu[c] = n + int'(hold_cycles);
          else
            m_sda[c] = frc ? 1'b1 : tg;
        end else if (scl_fall[c]) begin
          hu[c] = n + int'(hold_cycles);
        end
        m_arb[c] = set | (m_arb[c] & ~arb_clr[c]);
      end
      m_busy[c] = (n < hu[c]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sda_mode = 4'b0000; tx_out = 2'b00; scl_fall = 2'b00;
    hold_cycles = 4'd0; sda_in = 2'b11; arb_clr = 2'b00;
    tick();
    tick();
    checks++;
    if ({sda_out, busy, arb_lost} !== 6'b11_00_00) begin
      errors++;
      $display("FAIL reset got sda=%b busy=%b arb=%b exp sda=11 busy=00 arb=00",
               sda_out, busy, arb_lost);
    end
    rst = 1'b0;
  endtask

  task automatic test_modes();
    logic [0:7] e;
    e = 8'b11001101;
    hold_cycles = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sda_mode = {2'b00, 2'(i >> 1)};
      tx_out   = {1'b0, 1'(i & 1)};
      tick();
      checks++;
      if (sda_out !== {1'b1, e[i]}) begin
        errors++;
        $display("FAIL modes i=%0d got sda=%b exp sda=%b", i, sda_out, {1'b1, e[i]});
      end
      checks++;
      if ({sda_out, busy, arb_lost} !== {m_sda, m_busy, m_arb}) begin
        errors++;
        $display("FAIL modes_model i=%0d got %b/%b/%b exp %b/%b/%b",
                 i, sda_out, busy, arb_lost, m_sda, m_busy, m_arb);
      end
    end
  endtask

  task automatic test_hold();
    logic [0:4] eb, es;
    eb = 5'b11100;
    es = 5'b11110;
    hold_cycles = 4'd3;
    sda_mode = 4'b0011; tx_out = 2'b01; scl_fall = 2'b00;
    tick();
    tx_out = 2'b00; scl_fall = 2'b01;
    for (int k = 0; k < 5; k++) begin
      tick();
      scl_fall = 2'b00;
      checks++;
      if (busy[0] !== eb[k] || sda_out[0] !== es[k]) begin
        errors++;
        $display("FAIL hold edge=%0d got busy=%b sda=%b exp busy=%b sda=%b",
                 k, busy[0], sda_out[0], eb[k], es[k]);
      end
      checks++;
      if ({sda_out, busy, arb_lost} !== {m_sda, m_busy, m_arb}) begin
        errors++;
        $display("FAIL hold_model edge=%0d got %b/%b/%b exp %b/%b/%b",
                 k, sda_out, busy, arb_lost, m_sda, m_busy, m_arb);
      end
    end
  endtask

  task automatic test_reload();
    logic [0:7] eb, es;
    eb = 8'b11111100;
    es = 8'b11111110;
    sda_mode = 4'b0011; tx_out = 2'b01; scl_fall = 2'b00;
    tick();
    hold_cycles = 4'd4;
    tx_out = 2'b00;
    for (int k = 0; k < 8; k++) begin
      scl_fall = (k == 0 || k == 2) ? 2'b01 : 2'b00;
      tick();
      // A mid-window length change must not disturb the running count.
      if (k == 2) hold_cycles = 4'd1;
      checks++;
      if (busy[0] !== eb[k] || sda_out[0] !== es[k]) begin
        errors++;
        $display("FAIL reload edge=%0d got busy=%b sda=%b exp busy=%b sda=%b",
                 k, busy[0], sda_out[0], eb[k], es[k]);
      end
      checks++;
      if ({sda_out, busy, arb_lost} !== {m_sda, m_busy, m_arb}) begin
        errors++;
        $display("FAIL reload_model edge=%0d got %b/%b/%b exp %b/%b/%b",
                 k, sda_out, busy, arb_lost, m_sda, m_busy, m_arb);
      end
    end
    scl_fall = 2'b00;
  endtask

  task automatic test_reset_mid_hold();
    hold_cycles = 4'd4;
    sda_mode = 4'b0011; tx_out = 2'b00;
    tick();
    scl_fall = 2'b01;
    tick();
    scl_fall = 2'b00;
    tick();
    tick();
    checks++;
    if (busy !== 2'b01 || sda_out !== 2'b10) begin
      errors++;
      $display("FAIL pre_reset got busy=%b sda=%b exp busy=01 sda=10", busy, sda_out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (sda_out !== 2'b11 || busy !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset got sda=%b busy=%b exp sda=11 busy=00", sda_out, busy);
    end
    rst = 1'b0;
    sda_mode = 4'b0001;
    tick();
    checks++;
    if (sda_out !== 2'b10 || busy !== 2'b00) begin
      errors++;
      $display("FAIL post_reset got sda=%b busy=%b exp sda=10 busy=00", sda_out, busy);
    end
  endtask

  task automatic test_arb();
    hold_cycles = 4'd0; scl_fall = 2'b00; arb_clr = 2'b00;
    sda_mode = 4'b1100; tx_out = 2'b10; sda_in = 2'b11;
    tick();
    sda_in = 2'b01;
    tick();
    checks++;
    if (arb_lost[1] !== ARB || sda_out[1] !== 1'b1) begin
      errors++;
      $display("FAIL arb_set got arb=%b sda=%b exp arb=%b sda=1",
               arb_lost[1], sda_out[1], ARB);
    end
    sda_in = 2'b11; tx_out = 2'b00;
    tick();
    checks++;
    if (arb_lost[1] !== ARB || sda_out[1] !== ARB) begin
      errors++;
      $display("FAIL arb_force got arb=%b sda=%b exp arb=%b sda=%b",
               arb_lost[1], sda_out[1], ARB, ARB);
    end
    arb_clr = 2'b10; sda_in = 2'b01;
    tick();
    checks++;
    if (arb_lost[1] !== ARB) begin
      errors++;
      $display("FAIL arb_set_wins got arb=%b exp arb=%b", arb_lost[1], ARB);
    end
    sda_in = 2'b11;
    tick();
    checks++;
    if (arb_lost[1] !== 1'b0) begin
      errors++;
      $display("FAIL arb_clr got arb=%b exp arb=0", arb_lost[1]);
    end
    arb_clr = 2'b00;
    tick();
    checks++;
    if (sda_out[1] !== 1'b0 || arb_lost !== 2'b00) begin
      errors++;
      $display("FAIL arb_resume got sda=%b arb=%b exp sda=0 arb=00",
               sda_out[1], arb_lost);
    end
    checks++;
    if ({sda_out, busy, arb_lost} !== {m_sda, m_busy, m_arb}) begin
      errors++;
      $display("FAIL arb_model got %b/%b/%b exp %b/%b/%b",
               sda_out, busy, arb_lost, m_sda, m_busy, m_arb);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(99) == 0);
      sda_mode    = 4'($urandom);
      tx_out      = 2'($urandom);
      scl_fall[0] = ($urandom_range(5) == 0);
      scl_fall[1] = ($urandom_range(5) == 0);
      hold_cycles = 4'($urandom_range(5));
      sda_in[0]   = ($urandom_range(7) != 0);
      sda_in[1]   = ($urandom_range(7) != 0);
      arb_clr[0]  = ($urandom_range(7) == 0);
      arb_clr[1]  = ($urandom_range(7) == 0);
      tick();
      checks++;
      if ({sda_out, busy, arb_lost} !== {m_sda, m_busy, m_arb}) begin
        errors++;
        $display("FAIL random i=%0d got %b/%b/%b exp %b/%b/%b",
                 i, sda_out, busy, arb_lost, m_sda, m_busy, m_arb);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    hu[0] = 0;
    hu[1] = 0;
    test_reset();
    test_modes();
    test_hold();
    test_reload();
    test_reset_mid_hold();
    test_arb();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
